// File: rtl/parity_block_accumulator.sv
// LDPC encoder parity accumulator: rotates each selected block by its per-row
// shift within the active lifting size and XORs it into the row's accumulator.
module parity_block_accumulator #(
  parameter int ROWS   = 23,
  parameter int MAX_ZC = 384,
  parameter int ZC_W   = 9,
  parameter int COL_W  = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ZC_W-1:0]                zc,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [ROWS-1:0][MAX_ZC-1:0]    in_blocks,
  input  logic [ROWS-1:0]                row_en,
  input  logic [ROWS-1:0][ZC_W-1:0]      shift_vals,
  output logic [ROWS-1:0][MAX_ZC-1:0]    acc_blocks,
  output logic [COL_W-1:0]               col_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           err_shift
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                         state_r;
  logic [ROWS-1:0][MAX_ZC-1:0]    acc_r;
  logic [ROWS-1:0][MAX_ZC-1:0]    next_acc_s;
  logic [COL_W-1:0]               col_r;
  logic                           ready_r;
  logic                           valid_r;
  logic                           err_r;
  logic [MAX_ZC-1:0]              mask_s;
  logic                           accept_s;
  logic                           bad_shift_s;

  function automatic logic [MAX_ZC-1:0] zc_mask(input logic [ZC_W-1:0] z);
    logic [MAX_ZC-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ZC; i++) begin
      m[i] = (i < int'(z));
    end
    return m;
  endfunction

  // Right rotation inside the low z bits: the masked block shifted down by s,
  // with the bits that fall off the bottom wrapped back in at position z-s.
  function automatic logic [MAX_ZC-1:0] rotate_block(
    input logic [MAX_ZC-1:0] blk,
    input logic [MAX_ZC-1:0] mask,
    input logic [ZC_W-1:0]   z,
    input logic [ZC_W-1:0]   s
  );
    logic [MAX_ZC-1:0] b;
    b = blk & mask;
    return ((b >> s) | (b << (z - s))) & mask;
  endfunction

  assign accept_s   = in_valid & ready_r;
  assign mask_s     = zc_mask(zc);
  assign acc_blocks = acc_r;
  assign col_count  = col_r;
  assign in_ready   = ready_r;
  assign out_valid  = valid_r;
  assign err_shift  = err_r;

  // Next accumulator value per row and detection of out-of-range shifts.
  always_comb begin
    next_acc_s  = '0;
    bad_shift_s = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      logic [MAX_ZC-1:0] contrib;
      if (row_en[r] && (shift_vals[r] < zc)) begin
        contrib = rotate_block(in_blocks[r], mask_s, zc, shift_vals[r]);
      end else begin
        contrib = '0;
      end
      if (in_first) begin
        next_acc_s[r] = contrib & mask_s;
      end else begin
        next_acc_s[r] = (acc_r[r] ^ contrib) & mask_s;
      end
      bad_shift_s = bad_shift_s | (row_en[r] & (shift_vals[r] >= zc));
    end
  end

  // Control FSM, accumulators, column counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= '0;
      col_r   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= next_acc_s;
            if (bad_shift_s) begin
              err_r <= 1'b1;
            end
            if (in_first) begin
              col_r <= COL_W'(1);
            end else if (col_r != {COL_W{1'b1}}) begin
              col_r <= col_r + COL_W'(1);
            end
            if (in_last) begin
              state_r <= HOLD;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r <= ACCUM;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ACCUM;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_block_accumulator.sv
// Directed bench for parity_block_accumulator: table of single-row beats plus
// hand sequences for shift errors, HOLD back-pressure and mid-codeword reset.
module tb_parity_block_accumulator;

  localparam int ROWS = 23;
  localparam int MZ   = 384;
  localparam int ZW   = 9;
  localparam int CW   = 7;

  logic                      clk;
  logic                      rst;
  logic [ZW-1:0]             zc;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_first;
  logic                      in_last;
  logic [ROWS-1:0][MZ-1:0]   in_blocks;
  logic [ROWS-1:0]           row_en;
  logic [ROWS-1:0][ZW-1:0]   shift_vals;
  logic [ROWS-1:0][MZ-1:0]   acc_blocks;
  logic [CW-1:0]             col_count;
  logic                      out_valid;
  logic                      out_ready;
  logic                      err_shift;

  int total = 0;
  int bad   = 0;

  parity_block_accumulator #(
    .ROWS(ROWS), .MAX_ZC(MZ), .ZC_W(ZW), .COL_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .zc(zc),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .in_blocks(in_blocks), .row_en(row_en), .shift_vals(shift_vals),
    .acc_blocks(acc_blocks), .col_count(col_count),
    .out_valid(out_valid), .out_ready(out_ready), .err_shift(err_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           first;
    bit           last;
    int           z;
    int           row;
    logic [MZ-1:0] blk;
    int           sh;
    logic [MZ-1:0] exp_acc;
    int           exp_col;
    bit           exp_ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [MZ-1:0] act, input logic [MZ-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one beat with a single row (optionally) enabled; other rows carry junk.
  task automatic beat(input bit f, input bit l, input int z, input int row,
                      input logic [MZ-1:0] blk, input int sh, input bit en);
    for (int r = 0; r < ROWS; r++) begin
      in_blocks[r]  = {12{32'hA5A5_5A5A}};
      shift_vals[r] = 9'd0;
    end
    in_blocks[row]  = blk;
    shift_vals[row] = ZW'(sh);
    row_en          = '0;
    row_en[row]     = en;
    zc       = ZW'(z);
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", MZ'(out_valid), MZ'(0));
    chk("release_in_ready", MZ'(in_ready), MZ'(1));
  endtask

  initial begin
    rst = 1'b1; zc = 9'd8; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_blocks = '0; row_en = '0; shift_vals = '0; out_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b1,   8,  0, MZ'(32'h01),   3, MZ'(32'h20),   1, 1'b1};
    vecs[1] = '{1'b1, 1'b0,  16,  2, MZ'(32'h00FF), 0, MZ'(32'h00FF), 1, 1'b0};
    vecs[2] = '{1'b0, 1'b0,  16,  2, MZ'(32'h0F0F), 4, MZ'(32'hF00F), 2, 1'b0};
    vecs[3] = '{1'b0, 1'b1,  16,  2, MZ'(32'hFFFF), 0, MZ'(32'h0FF0), 3, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 384, 22, MZ'(32'h1),  383, MZ'(32'h2),    1, 1'b1};
    vecs[5] = '{1'b1, 1'b1,   8,  7, {MZ{1'b1}},    0, MZ'(32'hFF),   1, 1'b1};
    vecs[6] = '{1'b1, 1'b0,  12,  3, MZ'(32'h801),  1, MZ'(32'hC00),  1, 1'b0};
    vecs[7] = '{1'b0, 1'b1,  12,  3, MZ'(32'h003), 11, MZ'(32'hC06),  2, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_acc_zero", MZ'(|acc_blocks), MZ'(0));
    chk("reset_col", MZ'(col_count), MZ'(0));
    chk("reset_out_valid", MZ'(out_valid), MZ'(0));
    chk("reset_in_ready", MZ'(in_ready), MZ'(1));
    chk("reset_err", MZ'(err_shift), MZ'(0));

    for (int i = 0; i < 8; i++) begin
      beat(vecs[i].first, vecs[i].last, vecs[i].z, vecs[i].row, vecs[i].blk, vecs[i].sh, 1'b1);
      chk($sformatf("vec%0d_acc", i), acc_blocks[vecs[i].row], vecs[i].exp_acc);
      chk($sformatf("vec%0d_col", i), MZ'(col_count), MZ'(vecs[i].exp_col));
      chk($sformatf("vec%0d_out_valid", i), MZ'(out_valid), MZ'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_in_ready", i), MZ'(in_ready), MZ'(!vecs[i].exp_ov));
      chk($sformatf("vec%0d_row5", i), acc_blocks[5], MZ'(0));
      chk($sformatf("vec%0d_err", i), MZ'(err_shift), MZ'(0));
      if (vecs[i].exp_ov) begin
        release_hold();
        chk($sformatf("vec%0d_retained", i), acc_blocks[vecs[i].row], vecs[i].exp_acc);
      end
    end

    // Out-of-range shift: row contributes nothing and the error is sticky.
    beat(1'b1, 1'b1, 384, 4, MZ'(32'hFF), 384, 1'b1);
    chk("badshift_acc", acc_blocks[4], MZ'(0));
    chk("badshift_err", MZ'(err_shift), MZ'(1));
    release_hold();
    beat(1'b1, 1'b1, 16, 4, MZ'(32'h1), 0, 1'b1);
    chk("badshift_err_sticky", MZ'(err_shift), MZ'(1));
    chk("goodshift_acc", acc_blocks[4], MZ'(32'h1));
    release_hold();

    // Back-pressure in HOLD with a pending first beat.
    beat(1'b1, 1'b1, 16, 1, MZ'(32'h0003), 1, 1'b1);
    chk("hold_acc", acc_blocks[1], MZ'(32'h8001));
    in_blocks[1] = MZ'(32'h00F0); shift_vals[1] = 9'd4; row_en = '0; row_en[1] = 1'b1;
    in_first = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_acc", c), acc_blocks[1], MZ'(32'h8001));
      chk($sformatf("stall%0d_col", c), MZ'(col_count), MZ'(1));
      chk($sformatf("stall%0d_out_valid", c), MZ'(out_valid), MZ'(1));
      chk($sformatf("stall%0d_in_ready", c), MZ'(in_ready), MZ'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("unstall_out_valid", MZ'(out_valid), MZ'(0));
    chk("unstall_in_ready", MZ'(in_ready), MZ'(1));
    chk("unstall_acc_kept", acc_blocks[1], MZ'(32'h8001));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pending_acc", acc_blocks[1], MZ'(32'h000F));
    chk("pending_col", MZ'(col_count), MZ'(1));
    chk("pending_out_valid", MZ'(out_valid), MZ'(0));

    // Reset partway through a four-beat codeword, then a clean rerun.
    beat(1'b1, 1'b0, 16, 6, MZ'(32'h1234), 0, 1'b1);
    beat(1'b0, 1'b0, 16, 6, MZ'(32'h00F0), 4, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_acc_zero", MZ'(|acc_blocks), MZ'(0));
    chk("midrst_col", MZ'(col_count), MZ'(0));
    chk("midrst_out_valid", MZ'(out_valid), MZ'(0));
    chk("midrst_err", MZ'(err_shift), MZ'(0));
    chk("midrst_in_ready", MZ'(in_ready), MZ'(1));
    beat(1'b1, 1'b0, 16, 6, MZ'(32'h1234), 0, 1'b1);
    beat(1'b0, 1'b0, 16, 6, MZ'(32'h00F0), 4, 1'b1);
    beat(1'b0, 1'b0, 16, 6, MZ'(32'h8000), 15, 1'b1);
    chk("rerun_partial", acc_blocks[6], MZ'(32'h123A));
    beat(1'b0, 1'b1, 16, 6, MZ'(32'h0001), 0, 1'b1);
    chk("rerun_acc", acc_blocks[6], MZ'(32'h123B));
    chk("rerun_col", MZ'(col_count), MZ'(4));
    chk("rerun_out_valid", MZ'(out_valid), MZ'(1));
    release_hold();

    // Disabled row with nonzero data leaves its accumulator untouched.
    beat(1'b1, 1'b1, 16, 5, MZ'(32'hFFFF), 0, 1'b0);
    chk("row5_disabled", acc_blocks[5], MZ'(0));
    release_hold();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
